mdr_handshake: RTL

Parametrised memory data register for the datapath. It keeps the bus-load and direct-memory-load paths of the existing 32-bit MDR. It adds a request/acknowledge memory handshake with variable wait states, byte/halfword/word sizing with optional sign extension, and byte-enable generation for writes. It sits between the CPU bus (bus_mux_out) and the memory subsystem, and is driven by the control unit.

---
 rtl/mdr_handshake.sv | 90 +++++++++
 1 files changed

// File: rtl/mdr_handshake.sv
// mdr_handshake: memory data register with req/ack handshake, sized reads and byte enables (optional timeout via MDR_TIMEOUT_EN)
module mdr_handshake #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   bus_mux_out,
  input  logic                    MDRin,
  input  logic                    select,
  input  logic                    rd_req,
  input  logic                    wr_req,
  input  logic [1:0]              size,
  input  logic                    sign,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mdr_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int BW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
  state_t state, next;
  logic [1:0] size_q;
  logic sign_q, accept, finish, tmo, ext;
  logic [DATA_WIDTH-1:0] mask, rd_val;
  if (DATA_WIDTH < 16 || DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mdr_handshake: illegal parameters");
  end
  assign mem_wdata = mdr_out;
  // state register; clear drops any transfer (and its strobe) at once
  always_ff @(posedge clk or posedge clear)
    if (clear) state <= IDLE;
    else       state <= next;
  // next state, strobes and sized/extended read data
  always_comb begin
    accept = (state == IDLE) && (rd_req || wr_req);
    finish = (state != IDLE) && (mem_ack || tmo);
    next   = state == IDLE ? (rd_req ? RD_WAIT : wr_req ? WR_WAIT : IDLE) : finish ? IDLE : state;
    mem_rd = state == RD_WAIT;
    mem_wr = state == WR_WAIT;
    busy   = state != IDLE;
    mask   = size_q[1] ? {DATA_WIDTH{1'b1}} : size_q[0] ? DATA_WIDTH'('hFFFF) : DATA_WIDTH'('hFF);
    ext    = sign_q & (size_q[0] ? mem_rdata[15] : mem_rdata[7]);
    rd_val = (mem_rdata & mask) | ({DATA_WIDTH{ext}} & ~mask);
  end
  // register contents, captured request attributes and completion pulse
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      mdr_out <= '0;
      mem_be  <= '0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        size_q <= size;
        sign_q <= sign;
        mem_be <= size[1] ? {BW{1'b1}} : BW'(size[0] ? 3 : 1);
      end
      if (state == RD_WAIT && mem_ack) mdr_out <= rd_val;
      else if (state == IDLE && !rd_req && !wr_req && MDRin) mdr_out <= select ? mem_rdata : bus_mux_out;
    end
`ifdef MDR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  // wait-state counter and sticky abort flag; an ack on the limit cycle wins
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (busy && !mem_ack) begin
      cnt <= cnt + 1'b1;
      if (tmo) err <= 1'b1;
    end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
endmodule
